// File: rtl/wb_arbiter_pkg.sv
// Shared types and instantiation constants for the write-back arbiter and
// the functional-unit wrapper.
package wb_arbiter_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned DataWidth = 32;

  // Defaults used by the functional-unit wrapper when instantiating wb_arbiter
  localparam int unsigned NR_WB_SRC    = 4;
  localparam int unsigned WB_BUF_DEPTH = 2;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] result;
  } fu_output_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               valid;
  } completion_port_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer: DEPTH-entry FIFO with wrapping pointers and an
// occupancy counter; storage itself is not reset.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  fu_output_t wdata_i,
  output logic       full_o,
  output logic       empty_o,
  output fu_output_t head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fu_output_t      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: buffers FU results per source and grants up
// to NR_PORTS non-empty sources per cycle, starting from rr_ptr.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_SRC    = 4,
  parameter int unsigned NR_PORTS  = 2,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               flush_i,
  input  fu_output_t       [NR_SRC-1:0]      src_i,
  input  logic             [NR_SRC-1:0]      src_valid_i,
  output logic             [NR_SRC-1:0]      src_ready_o,
  output fu_output_t       [NR_PORTS-1:0]    wb_o,
  output logic             [NR_PORTS-1:0]    wb_valid_o,
  output completion_port_t [NR_PORTS-1:0]    compl_o
);

  localparam int unsigned SrcW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic       [NR_SRC-1:0] full, empty, push, pop;
  fu_output_t [NR_SRC-1:0] head;
  logic       [SrcW-1:0]   rr_ptr_q, rr_ptr_d;

  // Ready comes from registered occupancy only: a full buffer stays closed
  // even when its head leaves this cycle.
  assign src_ready_o = ~full & {NR_SRC{~flush_i}};
  assign push        = src_valid_i & src_ready_o;

  for (genvar i = 0; i < NR_SRC; i++) begin : g_fifo
    wb_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .wdata_i (src_i[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i])
    );
  end

  always_comb begin
    int unsigned     n;
    logic [SrcW-1:0] idx;
    logic [SrcW-1:0] last;
    logic            any;
    wb_o       = '0;
    wb_valid_o = '0;
    pop        = '0;
    n          = 0;
    idx        = '0;
    last       = '0;
    any        = 1'b0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      idx = SrcW'((32'(rr_ptr_q) + k) % NR_SRC);
      if (!flush_i && !empty[idx] && (n < NR_PORTS)) begin
        // The n-th grant in scan order lands on port n.
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
          if (p == n) begin
            wb_o[p]       = head[idx];
            wb_valid_o[p] = 1'b1;
          end
        end
        pop[idx] = 1'b1;
        last     = idx;
        any      = 1'b1;
        n        = n + 1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any) rr_ptr_d = (last == SrcW'(NR_SRC - 1)) ? '0 : last + 1'b1;
  end

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      compl_o[p].id    = wb_o[p].id;
      compl_o[p].valid = wb_valid_o[p];
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// stream, all compared against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int BD = 2;

  logic                           clk = 1'b0;
  logic                           rstn = 1'b0;
  logic                           flush_i = 1'b0;
  fu_output_t       [NS-1:0]      src_i = '0;
  logic             [NS-1:0]      src_valid_i = '0;
  logic             [NS-1:0]      src_ready_o;
  fu_output_t       [NP-1:0]      wb_o;
  logic             [NP-1:0]      wb_valid_o;
  completion_port_t [NP-1:0]      compl_o;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per source plus the scan start index.
  fu_output_t mq [NS][$];
  int         rr;
  fu_output_t exp_wb [NP];
  logic [NP-1:0] exp_valid;
  logic [NS-1:0] exp_ready, exp_grant, taken;
  int         exp_last;
  logic [1:0] seq [NS];

  wb_arbiter #(
    .NR_SRC    (NS),
    .NR_PORTS  (NP),
    .BUF_DEPTH (BD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (flush_i),
    .src_i       (src_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .wb_o        (wb_o),
    .wb_valid_o  (wb_valid_o),
    .compl_o     (compl_o)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NS; i++) mq[i].delete();
    rr = 0;
  endtask

  task automatic model_eval();
    int n;
    n = 0;
    exp_last  = -1;
    exp_valid = '0;
    exp_grant = '0;
    for (int p = 0; p < NP; p++) exp_wb[p] = '0;
    for (int i = 0; i < NS; i++) exp_ready[i] = (mq[i].size() < BD) && !flush_i;
    if (!flush_i) begin
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (rr + k) % NS;
        if (mq[s].size() > 0 && n < NP) begin
          exp_wb[n]    = mq[s][0];
          exp_valid[n] = 1'b1;
          exp_grant[s] = 1'b1;
          exp_last     = s;
          n++;
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NS; i++) taken[i] = src_valid_i[i] && exp_ready[i];
    if (flush_i) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < NS; i++) if (exp_grant[i]) void'(mq[i].pop_front());
      for (int i = 0; i < NS; i++) if (taken[i]) mq[i].push_back(src_i[i]);
      if (exp_last >= 0) rr = (exp_last + 1) % NS;
    end
  endtask

  // A source keeps its pending result until it is accepted.
  task automatic set_inputs(input logic [NS-1:0] v, input logic f);
    for (int i = 0; i < NS; i++) begin
      if (v[i] && (!src_valid_i[i] || taken[i])) begin
        src_i[i].id     = {2'(i), seq[i]};
        src_i[i].result = $urandom;
        seq[i]          = seq[i] + 2'd1;
      end
    end
    src_valid_i = v;
    flush_i     = f;
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    src_valid_i = '0;
    flush_i     = 1'b0;
    taken       = '1;
    rstn        = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
  endtask

  task automatic test_reset();
    src_valid_i = '0;
    flush_i     = 1'b0;
    rstn        = 1'b1;
    #2;
    checks++;
    if (wb_valid_o !== '0 || wb_o !== '0 || src_ready_o !== '1) begin
      errors++;
      $display("FAIL reset_state valid=%b wb=%h ready=%b, want 00 0 1111",
               wb_valid_o, wb_o, src_ready_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    completion_port_t c;
    do_reset();
    set_inputs(4'b0100, 1'b0);
    src_i[2].id = 4'd5;
    settle();
    checks++;
    if (wb_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL single_no_bypass valid=%b want 00", wb_valid_o);
    end
    advance();
    set_inputs(4'b0000, 1'b0);
    settle();
    c.id = 4'd5;
    c.valid = 1'b1;
    checks++;
    if (wb_valid_o !== 2'b01 || wb_o[0].id !== 4'd5 || compl_o[0] !== c
        || compl_o[1].valid !== 1'b0 || wb_o[1] !== '0) begin
      errors++;
      $display("FAIL single_result valid=%b id=%0d compl0=%h, want 01 5 %h",
               wb_valid_o, wb_o[0].id, compl_o[0], c);
    end
    advance();
  endtask

  task automatic test_stream(input int mode, input int cycles);
    int wait_cnt [NS];
    logic [1:0] want0, want1;
    fu_output_t sent1 [$];
    fu_output_t got1 [$];
    logic seen_full1;
    completion_port_t c;
    seen_full1 = 1'b0;
    for (int i = 0; i < NS; i++) wait_cnt[i] = 0;
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      logic [NS-1:0] v;
      logic f;
      f = 1'b0;
      if (mode == 0) begin
        v = '1;
      end else if (mode == 1) begin
        v = (cyc < cycles - 8) ? 4'b1101 : 4'b0000;
        v[1] = (sent1.size() < 3);
      end else begin
        v = 4'($urandom);
        for (int i = 0; i < NS; i++) if (src_valid_i[i] && !taken[i]) v[i] = 1'b1;
        f = ($urandom_range(0, 19) == 0);
        if (cyc >= cycles - 8) begin
          v = '0;
          f = 1'b0;
        end
      end
      set_inputs(v, f);
      settle();
      checks++;
      if (wb_valid_o !== exp_valid || src_ready_o !== exp_ready) begin
        errors++;
        $display("FAIL stream%0d_handshake cyc %0d valid=%b ready=%b want %b %b",
                 mode, cyc, wb_valid_o, src_ready_o, exp_valid, exp_ready);
      end
      for (int p = 0; p < NP; p++) begin
        c.id = exp_wb[p].id;
        c.valid = exp_valid[p];
        checks++;
        if (wb_o[p] !== exp_wb[p] || compl_o[p] !== c) begin
          errors++;
          $display("FAIL stream%0d_port%0d cyc %0d wb=%h compl=%h want %h %h",
                   mode, p, cyc, wb_o[p], compl_o[p], exp_wb[p], c);
        end
      end
      if (mode == 0) begin
        if (cyc >= 1 && cyc <= 3) begin
          want0 = (cyc == 2) ? 2'd2 : 2'd0;
          want1 = (cyc == 2) ? 2'd3 : 2'd1;
          checks++;
          if (wb_valid_o !== 2'b11 || wb_o[0].id[3:2] !== want0 || wb_o[1].id[3:2] !== want1) begin
            errors++;
            $display("FAIL rotate_grant cyc %0d src=%0d,%0d valid=%b want %0d,%0d 11",
                     cyc, wb_o[0].id[3:2], wb_o[1].id[3:2], wb_valid_o, want0, want1);
          end
        end
        for (int i = 0; i < NS; i++) begin
          logic g;
          g = 1'b0;
          for (int p = 0; p < NP; p++)
            if (wb_valid_o[p] && wb_o[p].id[3:2] == 2'(i)) g = 1'b1;
          wait_cnt[i] = (mq[i].size() > 0 && !g) ? wait_cnt[i] + 1 : 0;
          checks++;
          if (wait_cnt[i] > 2) begin
            errors++;
            $display("FAIL rotate_starve src %0d waited %0d want <=2", i, wait_cnt[i]);
          end
        end
      end
      if (mode == 1) begin
        for (int p = 0; p < NP; p++)
          if (wb_valid_o[p] && wb_o[p].id[3:2] == 2'd1) got1.push_back(wb_o[p]);
        if (mq[1].size() == BD) begin
          seen_full1 = 1'b1;
          checks++;
          if (src_ready_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_full cyc %0d ready1=%b want 0", cyc, src_ready_o[1]);
          end
        end
      end
      advance();
      if (mode == 1 && taken[1]) sent1.push_back(src_i[1]);
    end
    if (mode == 1) begin
      checks++;
      if (!seen_full1 || got1.size() != 3 || sent1.size() != 3) begin
        errors++;
        $display("FAIL b2b_count got %0d sent %0d full_seen %0d want 3 3 1",
                 got1.size(), sent1.size(), seen_full1);
      end else begin
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (got1[j] !== sent1[j]) begin
            errors++;
            $display("FAIL b2b_order %0d got %h want %h", j, got1[j], sent1[j]);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_inputs(4'b1110, 1'b0);
    settle();
    advance();
    set_inputs(4'b1110, 1'b0);
    settle();
    advance();
    set_inputs(4'b0001, 1'b1);
    settle();
    checks++;
    if (wb_valid_o !== 2'b00 || src_ready_o !== 4'b0000 || exp_valid !== 2'b00) begin
      errors++;
      $display("FAIL flush_cycle valid=%b ready=%b want 00 0000", wb_valid_o, src_ready_o);
    end
    advance();
    for (int cyc = 0; cyc < 3; cyc++) begin
      set_inputs(4'b0000, 1'b0);
      settle();
      checks++;
      if (wb_valid_o !== 2'b00 || src_ready_o !== 4'b1111) begin
        errors++;
        $display("FAIL flush_after cyc %0d valid=%b ready=%b want 00 1111",
                 cyc, wb_valid_o, src_ready_o);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int cyc = 0; cyc < 2; cyc++) begin
      set_inputs('1, 1'b0);
      settle();
      advance();
    end
    set_inputs('1, 1'b0);
    settle();
    rstn = 1'b1;
    #2;
    checks++;
    if (wb_valid_o !== 2'b00 || wb_o !== '0 || src_ready_o !== 4'b1111) begin
      errors++;
      $display("FAIL async_reset valid=%b ready=%b want 00 1111", wb_valid_o, src_ready_o);
    end
    src_valid_i = '0;
    taken = '1;
    model_clear();
    @(posedge clk);
    #1 rstn = 1'b0;
    set_inputs(4'b1010, 1'b0);
    settle();
    advance();
    set_inputs(4'b0000, 1'b0);
    settle();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_o[0].id[3:2] !== 2'd1 || wb_o[1].id[3:2] !== 2'd3
        || wb_o[0] !== exp_wb[0] || wb_o[1] !== exp_wb[1]) begin
      errors++;
      $display("FAIL async_first_grant valid=%b src=%0d,%0d want 11 1,3",
               wb_valid_o, wb_o[0].id[3:2], wb_o[1].id[3:2]);
    end
    advance();
  endtask

  task automatic test_full_dequeue();
    do_reset();
    for (int cyc = 0; cyc < 2; cyc++) begin
      set_inputs('1, 1'b0);
      settle();
      advance();
    end
    set_inputs('1, 1'b0);
    settle();
    checks++;
    if (src_ready_o[3] !== 1'b0 || wb_valid_o !== 2'b11 || wb_o[1].id[3:2] !== 2'd3) begin
      errors++;
      $display("FAIL full_deq_same ready3=%b valid=%b src1=%0d want 0 11 3",
               src_ready_o[3], wb_valid_o, wb_o[1].id[3:2]);
    end
    advance();
    set_inputs(4'b0000, 1'b0);
    settle();
    checks++;
    if (src_ready_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL full_deq_next ready3=%b want 1", src_ready_o[3]);
    end
    advance();
  endtask

  initial begin
    taken = '1;
    for (int i = 0; i < NS; i++) seq[i] = 2'd0;
    model_clear();
    #1;
    test_reset();
    test_single();
    test_stream(0, 12);
    test_stream(1, 20);
    test_flush();
    test_async_reset();
    test_full_dequeue();
    test_stream(2, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NR_SRC, default 4: number of FU result sources.
REQ-002 SHALL have parameter NR_PORTS, default 2: number of write-back ports, 1 <= NR_PORTS <= NR_SRC.
REQ-003 SHALL have parameter BUF_DEPTH, default 2: per-source result buffer depth, power of two, >= 2.
REQ-004 SHALL have port clk  input  1  core clock, rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous reset, active-high (asserted = 1).
REQ-006 SHALL have port flush_i  input  1  discard all buffered and incoming results.
REQ-007 SHALL have port src_i  input  NR_SRC x fu_output_t  FU results.
REQ-008 SHALL have port src_valid_i  input  NR_SRC  per-source result valid.
REQ-009 SHALL have port src_ready_o  output  NR_SRC  per-source buffer can accept.
REQ-010 SHALL have port wb_o  output  NR_PORTS x fu_output_t  write-back data to regfile.
REQ-011 SHALL have port wb_valid_o  output  NR_PORTS  write-back valid.
REQ-012 SHALL have port compl_o  output  NR_PORTS x completion_port_t  ROB completion; id = wb_o[k].id, valid = wb_valid_o[k].

Function
REQ-013 SHALL hold one FIFO of BUF_DEPTH fu_output_t entries per source, with read/write pointers wrapping modulo BUF_DEPTH and count 0..BUF_DEPTH.
REQ-014 SHALL drive src_ready_o[i] = (count[i] < BUF_DEPTH) && !flush_i, from registered state only; no pass-through when full, even if the head dequeues that cycle.
REQ-015 SHALL enqueue src_i[i] on a clock edge where src_valid_i[i] && src_ready_o[i]; valid with ready low SHALL be ignored (source holds).
REQ-016 SHALL present results no earlier than one cycle after acceptance; no same-cycle bypass from src_i to wb_o.
REQ-017 SHALL scan sources in order rr_ptr, rr_ptr+1, ... (mod NR_SRC) and grant the first up-to-NR_PORTS non-empty FIFOs; the k-th grant in scan order drives port k.
REQ-018 SHALL dequeue the head of every granted FIFO on the same clock edge; at most one entry per source per cycle.
REQ-019 SHALL set unused ports (fewer than NR_PORTS non-empty FIFOs) to wb_valid_o=0 and wb_o='0.
REQ-020 SHALL update rr_ptr to (index of last grant + 1) mod NR_SRC when at least one grant occurs; otherwise rr_ptr holds.
REQ-021 SHALL allow enqueue and dequeue on one source in the same cycle; count unchanged.
REQ-022 SHALL, while flush_i=1, force wb_valid_o=0, perform no dequeue or enqueue, and on that edge clear all counts and pointers; rr_ptr holds.
REQ-023 SHALL keep per-source result order (FIFO); no ordering guarantee across sources.

Reset
REQ-024 SHALL, while rstn=1, asynchronously clear all FIFO counts/pointers and rr_ptr to 0, giving wb_valid_o=0, wb_o='0, src_ready_o=all-ones (once flush_i=0).
REQ-025 SHALL discard in-flight buffered results on reset mid-operation; buffer storage need not be reset.

Structure
REQ-026 SHALL take fu_output_t, completion_port_t from package C; add NR_WB_SRC and WB_BUF_DEPTH constants to package C for instantiation by the functional-unit wrapper.
REQ-027 SHALL implement the per-source buffer as sub-module wb_fifo (params DEPTH; push/pop/full/empty/head), instantiated NR_SRC times.
REQ-028 SHALL keep the arbiter scan combinational (one pass over NR_SRC) feeding a registered rr_ptr; no other state.

Verification
REQ-029 SHALL check: after reset, one valid on src 2 (id=5) at cycle 0 -> wb_o[0].id=5, wb_valid_o=2'b01 at cycle 1, compl_o[0]={id 5, valid 1}.
REQ-030 SHALL check: all 4 sources valid each cycle, sinks drain -> port grants rotate {0,1},{2,3},{0,1}; no source starved >2 cycles.
REQ-031 SHALL check: src 1 pushes 3 results back-to-back while src 0,2,3 also stream -> src_ready_o[1]=0 when count=2, no result lost or duplicated, per-source ids in order.
REQ-032 SHALL check: flush_i pulsed with 3 FIFOs non-empty and src 0 valid -> wb_valid_o=0 that cycle, all FIFOs empty next cycle, src 0 result dropped.
REQ-033 SHALL check: rstn asserted asynchronously mid-stream (between edges) -> wb_valid_o=0 immediately, rr_ptr=0, first post-reset grant goes to lowest non-empty index.
REQ-034 SHALL check: full FIFO on src 3 with simultaneous dequeue -> src_ready_o[3]=0 that cycle, =1 next cycle.
